datamem_axi: RTL

//  Data-side AXI4 master for the RV32I core: single-beat writes through a WBUF_DEPTH-entry

---
 rtl/datamem_axi.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/datamem_axi.sv
// datamem_axi: data-side AXI4 master for the RV32I core; posted write buffer plus blocking reads ordered behind writes.
// Optional macro DATAMEM_RESP_ERR_EN adds sticky ERR/ERRADDR reporting of SLVERR/DECERR responses.
module datamem_axi #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 4,
    parameter int C_M_AXI_RUSER_WIDTH     = 4,
    parameter int C_M_AXI_BUSER_WIDTH     = 1,
    parameter int WBUF_DEPTH              = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]        WRADDR,
    input  logic                                 WREN,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]      WRSTRB,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]        WRDATA,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]        RDADDR,
    input  logic                                 RDEN,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        ORDADDR,
    output logic [C_M_AXI_DATA_WIDTH-1:0]        RDOUT,
    output logic                                 RDVALID,
    output logic                                 LOADING,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [7:0]                           M_AXI_AWLEN,
    output logic [2:0]                           M_AXI_AWSIZE,
    output logic [1:0]                           M_AXI_AWBURST,
    output logic                                 M_AXI_AWLOCK,
    output logic [3:0]                           M_AXI_AWCACHE,
    output logic [2:0]                           M_AXI_AWPROT,
    output logic [3:0]                           M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]      M_AXI_AWUSER,
    output logic                                 M_AXI_AWVALID,
    input  logic                                 M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                                 M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]       M_AXI_WUSER,
    output logic                                 M_AXI_WVALID,
    input  logic                                 M_AXI_WREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]                           M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]       M_AXI_BUSER,
    input  logic                                 M_AXI_BVALID,
    output logic                                 M_AXI_BREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [7:0]                           M_AXI_ARLEN,
    output logic [2:0]                           M_AXI_ARSIZE,
    output logic [1:0]                           M_AXI_ARBURST,
    output logic                                 M_AXI_ARLOCK,
    output logic [3:0]                           M_AXI_ARCACHE,
    output logic [2:0]                           M_AXI_ARPROT,
    output logic [3:0]                           M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]      M_AXI_ARUSER,
    output logic                                 M_AXI_ARVALID,
    input  logic                                 M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                           M_AXI_RRESP,
    input  logic                                 M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]       M_AXI_RUSER,
    input  logic                                 M_AXI_RVALID,
    output logic                                 M_AXI_RREADY
`ifdef DATAMEM_RESP_ERR_EN
    ,
    output logic                                 ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        ERRADDR
`endif
);

    // state   | meaning
    // W_IDLE  | no write in flight; pops the buffer head when non-empty
    // W_ADDR  | AW and/or W still waiting for their handshakes
    // W_RESP  | both handshakes done, waiting for B
    // R_IDLE  | no read pending; accepts RDEN
    // R_WAIT  | read latched, waiting for the write path to drain
    // R_ADDR  | ARVALID asserted
    // R_DATA  | RREADY asserted, waiting for RVALID

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [2:0]  AXSIZE  = 3'($clog2(SW));
    localparam logic [PW:0] PTR_ONE = 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_ADDR = 2'd2;
    localparam logic [1:0] R_DATA = 2'd3;

    logic [AW-1:0] wb_addr [WBUF_DEPTH];
    logic [SW-1:0] wb_strb [WBUF_DEPTH];
    logic [DW-1:0] wb_data [WBUF_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          wb_empty;
    logic          wb_full;
    logic          wb_push;
    logic          wb_pop;

    logic [1:0]    w_state;
    logic [1:0]    r_state;
    logic [AW-1:0] rd_addr_q;
    logic          aw_done;
    logic          w_done;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_BREADY  = 1'b1;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARUSER  = '0;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP, M_AXI_RID,
                             M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER};

    assign wb_empty = (wr_ptr == rd_ptr);
    assign wb_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign wb_pop   = (w_state == W_IDLE) && !wb_empty;
    // A full buffer still takes a write on the cycle its head is popped.
    assign wb_push  = WREN && (!wb_full || wb_pop);

    assign LOADING  = wb_full || (r_state != R_IDLE);

    always_ff @(posedge CLK) begin
        if (wb_push) begin
            wb_addr[wr_ptr[PW-1:0]] <= WRADDR;
            wb_strb[wr_ptr[PW-1:0]] <= WRSTRB;
            wb_data[wr_ptr[PW-1:0]] <= WRDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wb_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (wb_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done  = !M_AXI_WVALID || M_AXI_WREADY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state       <= W_IDLE;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wb_pop) begin
                        M_AXI_AWADDR  <= wb_addr[rd_ptr[PW-1:0]];
                        M_AXI_WSTRB   <= wb_strb[rd_ptr[PW-1:0]];
                        M_AXI_WDATA   <= wb_data[rd_ptr[PW-1:0]];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_WLAST   <= 1'b1;
                        w_state       <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                        M_AXI_WLAST  <= 1'b0;
                    end
                    if (aw_done && w_done) w_state <= W_RESP;
                end
                W_RESP: begin
                    if (M_AXI_BVALID) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= R_IDLE;
            rd_addr_q     <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_RREADY  <= 1'b0;
            RDVALID       <= 1'b0;
            RDOUT         <= '0;
            ORDADDR       <= '0;
        end else begin
            RDVALID <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (RDEN) begin
                        rd_addr_q <= RDADDR;
                        r_state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // Reads may not overtake any buffered or in-flight write.
                    if (wb_empty && (w_state == W_IDLE)) begin
                        M_AXI_ARADDR  <= rd_addr_q;
                        M_AXI_ARVALID <= 1'b1;
                        r_state       <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        RDOUT        <= M_AXI_RDATA;
                        ORDADDR      <= rd_addr_q;
                        RDVALID      <= 1'b1;
                        r_state      <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef DATAMEM_RESP_ERR_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR     <= 1'b0;
            ERRADDR <= '0;
        end else if (!ERR) begin
            if ((w_state == W_RESP) && M_AXI_BVALID && M_AXI_BRESP[1]) begin
                ERR     <= 1'b1;
                ERRADDR <= M_AXI_AWADDR;
            end else if ((r_state == R_DATA) && M_AXI_RVALID && M_AXI_RRESP[1]) begin
                ERR     <= 1'b1;
                ERRADDR <= M_AXI_ARADDR;
            end
        end
    end
`endif

endmodule
